em_pipe_stage: RTL and testbench
================================

// Module: em_pipe_stage
// PURPOSE
//  Parametrised EX->MEM pipeline stage that replaces the plain always-load EX/MEM register.
//  Carries the EX payload (WEN, DRW, DREQ, SelWB, WA, PCADD4, ALUOUT, DOUT0) with a
//  valid/ready handshake, a flush input and an optional 2-entry skid buffer.
//  With the handshake, a stalled data memory back-pressures EX without a combinational
//  ready path. Sits between the ALU stage and the data-memory/writeback logic.
// PARAMETERS
//  DATA_W   32  width of PCADD4, ALUOUT, DOUT0
//  WA_W     5   register-file write-address width
//  SKID_EN  1   1: 2-entry skid buffer, READY_E registered; 0: single slot, READY_E combinational
// PORTS
//  CLK       in   1       clock, rising edge
//  RST       in   1       asynchronous reset, active-high
//  FLUSH     in   1       synchronous discard of all held entries
//  VALID_E   in   1       EX payload valid
//  READY_E   out  1       stage can accept an EX payload this cycle
//  WEN_E     in   1       regfile write enable, active-low
//  DRW_E     in   1       data-memory read/write select
//  DREQ_E    in   1       data-memory request, active-low
//  SelWB_E   in   2       writeback mux select
//  WA_E      in   WA_W    writeback address
//  PCADD4_E  in   DATA_W  PC+4
//  ALUOUT_E  in   DATA_W  ALU result / memory address
//  DOUT0_E   in   DATA_W  store data
//  VALID_M   out  1       MEM payload valid
//  READY_M   in   1       MEM stage consumes the payload this cycle
//  WEN_M, DRW_M, DREQ_M, SelWB_M, WA_M, PCADD4_M, ALUOUT_M, DOUT0_M  out  as _E  held payload
//  OCC       out  2       entries held (0..2; max 1 when SKID_EN=0)
// BEHAVIOUR
//  - Reset (async, RST=1): VALID_M=0, OCC=0, WEN_M=1, DREQ_M=1, DRW_M=0, SelWB_M=0,
//    WA_M=0, PCADD4_M=ALUOUT_M=DOUT0_M=0. READY_E=1.
//  - Accept = VALID_E & READY_E. Emit = VALID_M & READY_M. Latency is 1 cycle from accept
//    to VALID_M when the stage is empty. Throughput is 1/cycle while READY_M=1.
//  - Bubble: while VALID_M=0, force WEN_M=1, DREQ_M=1, DRW_M=0, SelWB_M=0 (no write, no request).
//    Datapath outputs (WA, PCADD4, ALUOUT, DOUT0) keep their last value.
//  - SKID_EN=1 states: EMPTY(OCC=0), MAIN(1), BOTH(2). READY_E = (state!=BOTH), registered.
//    EMPTY: accept->MAIN.
//    MAIN: accept&emit->MAIN with new data. accept&~emit->BOTH (input goes to skid).
//      emit only->EMPTY.
//    BOTH: emit->MAIN, skid moves to main. No accept possible.
//    Order is strictly FIFO. Main always holds the oldest entry.
//  - SKID_EN=0: single slot. READY_E = READY_M | ~VALID_M (combinational). OCC is 0 or 1.
//  - FLUSH=1 at an edge: OCC->0 and VALID_M->0. Any simultaneous accept is dropped.
//    FLUSH wins over accept and emit. Bubble controls appear the next cycle.
//  - RST asserted mid-transfer: all entries are lost immediately, outputs take reset values.
//  - VALID_E must stay high with a stable payload until accepted. The bench checks this.
//    The DUT does not.
// STRUCTURE
//  - Shared package risc_toy_pkg holds: SelWB encodings, bubble constants
//    (WEN_IDLE=1, DREQ_IDLE=1, DRW_IDLE=0), and the packed em_payload_t struct
//    built from DATA_W and WA_W.
//  - Sub-module em_slot: a single payload register with load enable and async clear to reset values.
//    The stage instantiates two em_slot instances (main, skid).
//  - The FSM and the bubble gating live in em_pipe_stage.
// TESTING
//  1 Reset: RST=1 mid-stream -> VALID_M=0, OCC=0, WEN_M=1, DREQ_M=1, DRW_M=0, SelWB_M=0,
//    ALUOUT_M=0, READY_E=1.
//  2 Stream with READY_M=1: ALUOUT_E=0x10,0x20,0x30 on back-to-back cycles -> ALUOUT_M
//    shows the same values one cycle later, VALID_M=1 throughout, OCC=1.
//  3 Backpressure with READY_M=0: A,B,C offered -> A held at output, B in skid, OCC=2,
//    READY_E=0 from the next cycle, C held upstream. Then READY_M=1 -> A, B, C emitted
//    in order, no loss, no duplicates.
//  4 FLUSH with OCC=2 and VALID_E=1, WEN_E=0 -> next cycle OCC=0, VALID_M=0, WEN_M=1,
//    DREQ_M=1. The offered entry never appears.
//  5 SKID_EN=0, READY_M toggling 1,0,1 -> READY_E follows READY_M the same cycle while
//    VALID_M=1. No entry is lost or duplicated.
//  6 Emit and accept in the same cycle with OCC=1, ALUOUT 0x55 then 0x66 -> OCC stays 1,
//    ALUOUT_M=0x66 the next cycle.

Source files
------------

// File: rtl/risc_toy_pkg.sv
// Shared EX/MEM definitions: writeback select codes, bubble control values,
// the stage FSM encoding and the packed payload types.
package risc_toy_pkg;
  localparam int EM_DATA_W = 32;
  localparam int EM_WA_W   = 5;
  localparam int EM_CTRL_W = 5;

  localparam logic [1:0] SELWB_ALU = 2'd0;
  localparam logic [1:0] SELWB_MEM = 2'd1;
  localparam logic [1:0] SELWB_PC4 = 2'd2;
  localparam logic [1:0] SELWB_RSV = 2'd3;

  localparam logic WEN_IDLE  = 1'b1;
  localparam logic DREQ_IDLE = 1'b1;
  localparam logic DRW_IDLE  = 1'b0;

  // Encoding doubles as the occupancy count driven on OCC.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_BOTH  = 2'd2
  } em_state_e;

  typedef struct packed {
    logic       wen;
    logic       drw;
    logic       dreq;
    logic [1:0] selwb;
  } em_ctrl_t;

  localparam em_ctrl_t CTRL_IDLE = '{wen: WEN_IDLE, drw: DRW_IDLE, dreq: DREQ_IDLE, selwb: SELWB_ALU};

  typedef struct packed {
    em_ctrl_t              ctrl;
    logic [EM_WA_W-1:0]    wa;
    logic [EM_DATA_W-1:0]  pcadd4;
    logic [EM_DATA_W-1:0]  aluout;
    logic [EM_DATA_W-1:0]  dout0;
  } em_payload_t;

  function automatic em_ctrl_t gate_ctrl(input logic valid, input em_ctrl_t ctrl);
    if (valid) begin
      gate_ctrl = ctrl;
    end else begin
      gate_ctrl = CTRL_IDLE;
    end
  endfunction
endpackage

// File: rtl/em_slot.sv
// One EX/MEM payload register: loads when load=1, clears asynchronously to RST_VAL.
module em_slot
  import risc_toy_pkg::*;
#(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Next value: hold unless loaded.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // Payload storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;
endmodule

// File: rtl/em_pipe_stage.sv
// EX->MEM pipeline stage with valid/ready handshake, flush and optional
// 2-entry skid buffer (main slot always holds the oldest entry).
module em_pipe_stage
  import risc_toy_pkg::*;
#(
  parameter int DATA_W  = EM_DATA_W,
  parameter int WA_W    = EM_WA_W,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              VALID_E,
  output logic              READY_E,
  input  logic              WEN_E,
  input  logic              DRW_E,
  input  logic              DREQ_E,
  input  logic [1:0]        SelWB_E,
  input  logic [WA_W-1:0]   WA_E,
  input  logic [DATA_W-1:0] PCADD4_E,
  input  logic [DATA_W-1:0] ALUOUT_E,
  input  logic [DATA_W-1:0] DOUT0_E,
  output logic              VALID_M,
  input  logic              READY_M,
  output logic              WEN_M,
  output logic              DRW_M,
  output logic              DREQ_M,
  output logic [1:0]        SelWB_M,
  output logic [WA_W-1:0]   WA_M,
  output logic [DATA_W-1:0] PCADD4_M,
  output logic [DATA_W-1:0] ALUOUT_M,
  output logic [DATA_W-1:0] DOUT0_M,
  output logic [1:0]        OCC
);
  localparam int PAY_W = EM_CTRL_W + WA_W + 3 * DATA_W;
  localparam logic [PAY_W-1:0] PAY_RST = {CTRL_IDLE, {(WA_W + 3 * DATA_W){1'b0}}};

  em_state_e        state_d;
  em_state_e        state_q;
  logic             ready_e_d;
  logic             ready_e_q;
  logic             valid_m;
  logic             accept;
  logic             emit;
  logic             main_ld;
  logic             skid_ld;
  logic             main_from_skid;
  logic [PAY_W-1:0] pay_e;
  logic [PAY_W-1:0] main_in;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;
  em_ctrl_t         ctrl_m;

  assign pay_e   = {WEN_E, DRW_E, DREQ_E, SelWB_E, WA_E, PCADD4_E, ALUOUT_E, DOUT0_E};
  assign valid_m = (state_q != ST_EMPTY);
  // Without the skid slot, ready must look through to READY_M or we lose throughput.
  assign READY_E = SKID_EN ? ready_e_q : (READY_M | ~valid_m);
  assign accept  = VALID_E & READY_E;
  assign emit    = valid_m & READY_M;

  // Occupancy FSM and slot load control; FLUSH overrides accept and emit.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_MAIN;
            main_ld = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_MAIN: begin
          if (accept && emit) begin
            main_ld = 1'b1;
          end else if (accept && SKID_EN) begin
            skid_ld = 1'b1;
            state_d = ST_BOTH;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_MAIN;
          end
        end
        ST_BOTH: begin
          if (emit) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_MAIN;
          end else begin
            state_d = ST_BOTH;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Registered ready and main-slot input select.
  always_comb begin
    ready_e_d = 1'b1;
    main_in   = pay_e;
    if (state_d == ST_BOTH) begin
      ready_e_d = 1'b0;
    end else begin
      ready_e_d = 1'b1;
    end
    if (main_from_skid) begin
      main_in = skid_q;
    end else begin
      main_in = pay_e;
    end
  end

  // State and ready registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_EMPTY;
      ready_e_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ready_e_q <= ready_e_d;
    end
  end

  em_slot #(.W(PAY_W), .RST_VAL(PAY_RST)) u_main (
    .clk  (CLK),
    .rst  (RST),
    .load (main_ld),
    .d    (main_in),
    .q    (main_q)
  );

  em_slot #(.W(PAY_W), .RST_VAL(PAY_RST)) u_skid (
    .clk  (CLK),
    .rst  (RST),
    .load (skid_ld),
    .d    (pay_e),
    .q    (skid_q)
  );

  // Bubbles never write the regfile nor request memory; datapath fields keep their value.
  assign ctrl_m   = gate_ctrl(valid_m, em_ctrl_t'(main_q[PAY_W-1 -: EM_CTRL_W]));
  assign WEN_M    = ctrl_m.wen;
  assign DRW_M    = ctrl_m.drw;
  assign DREQ_M   = ctrl_m.dreq;
  assign SelWB_M  = ctrl_m.selwb;
  assign WA_M     = main_q[3 * DATA_W +: WA_W];
  assign PCADD4_M = main_q[2 * DATA_W +: DATA_W];
  assign ALUOUT_M = main_q[DATA_W +: DATA_W];
  assign DOUT0_M  = main_q[DATA_W-1:0];
  assign VALID_M  = valid_m;
  assign OCC      = state_q;
endmodule

// File: tb/tb_em_pipe_stage.sv
// Bench for em_pipe_stage: vector table plus hand sequences on a skid instance,
// and a single-slot instance; payloads are tracked by per-instance scoreboards.
module tb_em_pipe_stage;
  logic        CLK;
  logic        RST;
  logic        FLUSH;
  logic        VALID_E;
  logic        READY_M;
  logic [31:0] alu_e;
  logic        READY_E, VALID_M, WEN_M, DRW_M, DREQ_M;
  logic [1:0]  SelWB_M, OCC;
  logic [4:0]  WA_M;
  logic [31:0] PCADD4_M, ALUOUT_M, DOUT0_M;

  logic        flush0;
  logic        valid_e0;
  logic        ready_m0;
  logic [31:0] alu0;
  logic        READY_E0, VALID_M0, WEN_M0, DRW_M0, DREQ_M0;
  logic [1:0]  SelWB_M0, OCC0;
  logic [4:0]  WA_M0;
  logic [31:0] PCADD4_M0, ALUOUT_M0, DOUT0_M0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  typedef struct {
    logic        v;
    logic        rm;
    logic        fl;
    logic [31:0] alu;
    logic        x_valid;
    logic [1:0]  x_occ;
    logic        x_rdy;
    logic [31:0] x_alu;
  } vec_t;
  vec_t tbl [18];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Payload fields are all derived from the ALU value so one number identifies an entry.
  function automatic logic [105:0] mk_pay(input logic [31:0] a);
    mk_pay = {a[0], a[1], a[2], a[5:4], a[10:6], a + 32'd4, a, ~a};
  endfunction

  em_pipe_stage #(.DATA_W(32), .WA_W(5), .SKID_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .VALID_E(VALID_E), .READY_E(READY_E),
    .WEN_E(alu_e[0]), .DRW_E(alu_e[1]), .DREQ_E(alu_e[2]), .SelWB_E(alu_e[5:4]),
    .WA_E(alu_e[10:6]), .PCADD4_E(alu_e + 32'd4), .ALUOUT_E(alu_e), .DOUT0_E(~alu_e),
    .VALID_M(VALID_M), .READY_M(READY_M), .WEN_M(WEN_M), .DRW_M(DRW_M), .DREQ_M(DREQ_M),
    .SelWB_M(SelWB_M), .WA_M(WA_M), .PCADD4_M(PCADD4_M), .ALUOUT_M(ALUOUT_M),
    .DOUT0_M(DOUT0_M), .OCC(OCC)
  );

  em_pipe_stage #(.DATA_W(32), .WA_W(5), .SKID_EN(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .FLUSH(flush0), .VALID_E(valid_e0), .READY_E(READY_E0),
    .WEN_E(alu0[0]), .DRW_E(alu0[1]), .DREQ_E(alu0[2]), .SelWB_E(alu0[5:4]),
    .WA_E(alu0[10:6]), .PCADD4_E(alu0 + 32'd4), .ALUOUT_E(alu0), .DOUT0_E(~alu0),
    .VALID_M(VALID_M0), .READY_M(ready_m0), .WEN_M(WEN_M0), .DRW_M(DRW_M0), .DREQ_M(DREQ_M0),
    .SelWB_M(SelWB_M0), .WA_M(WA_M0), .PCADD4_M(PCADD4_M0), .ALUOUT_M(ALUOUT_M0),
    .DOUT0_M(DOUT0_M0), .OCC(OCC0)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard update just before the edge, then step to 1 time unit after it.
  task automatic tick();
    @(negedge CLK);
    if (!RST) begin
      if (FLUSH) begin
        q1.delete();
      end else begin
        if (VALID_M && READY_M) begin
          if (q1.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb1_underflow: got emit of %0h expected no output", ALUOUT_M);
          end else begin
            chk("sb1_payload", {WEN_M, DRW_M, DREQ_M, SelWB_M, WA_M, PCADD4_M, ALUOUT_M, DOUT0_M},
                mk_pay(q1.pop_front()));
          end
        end
        if (VALID_E && READY_E) q1.push_back(alu_e);
      end
      if (flush0) begin
        q0.delete();
      end else begin
        if (VALID_M0 && ready_m0) begin
          if (q0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb0_underflow: got emit of %0h expected no output", ALUOUT_M0);
          end else begin
            chk("sb0_payload", {WEN_M0, DRW_M0, DREQ_M0, SelWB_M0, WA_M0, PCADD4_M0, ALUOUT_M0, DOUT0_M0},
                mk_pay(q0.pop_front()));
          end
        end
        if (valid_e0 && READY_E0) q0.push_back(alu0);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, VALID_M, 1'b0);
    chk({tag, "_occ"}, OCC, 2'd0);
    chk({tag, "_wen"}, WEN_M, 1'b1);
    chk({tag, "_dreq"}, DREQ_M, 1'b1);
    chk({tag, "_drw"}, DRW_M, 1'b0);
    chk({tag, "_selwb"}, SelWB_M, 2'd0);
    chk({tag, "_alu"}, ALUOUT_M, 32'h0);
    chk({tag, "_ready"}, READY_E, 1'b1);
  endtask

  initial begin
    logic [5:0] pat;
    RST = 1'b1; FLUSH = 1'b0; VALID_E = 1'b0; READY_M = 1'b0; alu_e = 32'h0;
    flush0 = 1'b0; valid_e0 = 1'b0; ready_m0 = 1'b0; alu0 = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_vals("rst0");
    RST = 1'b0;

    //          v     rm    fl    alu        valid occ   rdy   alu_m
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 2'd1, 1'b1, 32'h10};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 2'd1, 1'b1, 32'h20};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h30, 1'b1, 2'd1, 1'b1, 32'h30};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 2'd0, 1'b1, 32'h30};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'hA1, 1'b1, 2'd1, 1'b1, 32'hA1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'hB2, 1'b1, 2'd2, 1'b0, 32'hA1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'hC3, 1'b1, 2'd2, 1'b0, 32'hA1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'hC3, 1'b1, 2'd1, 1'b1, 32'hB2};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'hC3, 1'b1, 2'd1, 1'b1, 32'hC3};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 2'd0, 1'b1, 32'hC3};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h55, 1'b1, 2'd1, 1'b1, 32'h55};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h66, 1'b1, 2'd1, 1'b1, 32'h66};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 2'd1, 1'b1, 32'h66};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h77, 1'b1, 2'd2, 1'b0, 32'h66};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h88, 1'b0, 2'd0, 1'b1, 32'h66};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h99, 1'b1, 2'd1, 1'b1, 32'h99};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 32'hAA, 1'b0, 2'd0, 1'b1, 32'h99};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 2'd0, 1'b1, 32'h99};

    for (int i = 0; i < 18; i++) begin
      VALID_E = tbl[i].v; READY_M = tbl[i].rm; FLUSH = tbl[i].fl; alu_e = tbl[i].alu;
      tick();
      FLUSH = 1'b0;
      chk($sformatf("v%0d_valid", i), VALID_M, tbl[i].x_valid);
      chk($sformatf("v%0d_occ", i), OCC, tbl[i].x_occ);
      chk($sformatf("v%0d_ready", i), READY_E, tbl[i].x_rdy);
      chk($sformatf("v%0d_alu", i), ALUOUT_M, tbl[i].x_alu);
      if (!tbl[i].x_valid) begin
        chk($sformatf("v%0d_bub_wen", i), WEN_M, 1'b1);
        chk($sformatf("v%0d_bub_dreq", i), DREQ_M, 1'b1);
        chk($sformatf("v%0d_bub_drw", i), DRW_M, 1'b0);
        chk($sformatf("v%0d_bub_selwb", i), SelWB_M, 2'd0);
      end
    end

    // Reset asserted mid-cycle with both slots full.
    VALID_E = 1'b1; READY_M = 1'b0; alu_e = 32'hD1;
    tick();
    alu_e = 32'hD2;
    tick();
    chk("mrst_pre_occ", OCC, 2'd2);
    #2;
    RST = 1'b1;
    #1;
    chk_reset_vals("mrst");
    q1.delete();
    q0.delete();
    VALID_E = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("mrst_post_occ", OCC, 2'd0);

    // Single-slot instance: READY_E tracks READY_M combinationally while full.
    alu0 = 32'h201; valid_e0 = 1'b1; ready_m0 = 1'b1;
    #1;
    chk("t5_ready_empty", READY_E0, 1'b1);
    tick();
    chk("t5_valid", VALID_M0, 1'b1);
    pat = 6'b110101;
    for (int i = 0; i < 6; i++) begin
      ready_m0 = pat[i];
      #1;
      chk($sformatf("t5_ready_%0d", i), READY_E0, pat[i]);
      chk($sformatf("t5_occ_%0d", i), OCC0, 2'd1);
      tick();
      if (pat[i]) alu0 = alu0 + 32'd1;
    end
    valid_e0 = 1'b0; ready_m0 = 1'b1;
    for (int k = 0; k < 10 && VALID_M0; k++) tick();
    chk("t5_drained", VALID_M0, 1'b0);

    chk("sb1_leftover", q1.size(), 0);
    chk("sb0_leftover", q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
